// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length,
// common command bytes and the frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_DEV,
        SHIFT,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam int FRAME_FALLS = 11;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // {stop, odd parity, data}; bit 0 goes on the wire first.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines, plus a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_sync_o,
    output logic data_sync_o,
    output logic clk_fall_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_sync_o  = clk_sync_q;
    assign data_sync_o = data_sync_q;
    assign clk_fall_o  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send,
// shifts one command frame on device clock falls and reads the ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int RTS_SETUP_CYCLES     = 100,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int XFER_TIMEOUT_CYCLES  = 200000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o
);

    localparam int TIMER_MAX = max_int(max_int(INHIBIT_CYCLES, RTS_SETUP_CYCLES),
                                       max_int(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
    localparam int TW = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] INHIBIT_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_LAST      = TW'(RTS_SETUP_CYCLES - 1);
    localparam logic [TW-1:0] START_LIMIT   = TW'(START_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] XFER_LIMIT    = TW'(XFER_TIMEOUT_CYCLES);
    localparam logic [3:0]    LAST_DATA_CNT = 4'(FRAME_FALLS - 1);

    ps2_tx_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic          ack_q, ack_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .clk_sync_o  (clk_sync),
        .data_sync_o (data_sync),
        .clk_fall_o  (clk_fall)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ack_q     <= ack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ack_d     = ack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_o    = 1'b0;
        ack_err_o = 1'b0;
        timeout_o = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (tx_start_i) begin
                    frame_d   = ps2_frame(tx_data_i);
                    bit_cnt_d = '0;
                    ack_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end
            end
            RTS: begin
                if (timer_q == RTS_LAST) begin
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                    state_d  = WAIT_DEV;
                end
            end
            // Timeout is tested before the fall so it wins a same-cycle tie.
            WAIT_DEV: begin
                if (timer_q == START_LIMIT) begin
                    timeout_o = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (timer_q == XFER_LIMIT) begin
                    timeout_o = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (clk_fall) begin
                    if (bit_cnt_q == LAST_DATA_CNT) begin
                        ack_d     = data_sync;
                        bit_cnt_d = 4'(FRAME_FALLS);
                        state_d   = WAIT_IDLE;
                    end else begin
                        data_oe_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (timer_q == XFER_LIMIT) begin
                    timeout_o = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (clk_sync && data_sync) begin
                    done_o    = 1'b1;
                    ack_err_o = ack_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timer_d   = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// over wired-AND lines; results are checked against frame rules computed here.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH      = 20;
    localparam int RTS_C    = 4;
    localparam int START_TO = 200;
    localparam int XFER_TO  = 2000;
    localparam int HALF     = 20;
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk;
    logic       dev_data;
    logic       clk_oe, data_oe, busy, done, ack_err, timeout;
    logic       ps2_clk_line, ps2_data_line;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Open-collector bus: either side may pull a line low.
    assign ps2_clk_line  = dev_clk & ~clk_oe;
    assign ps2_data_line = dev_data & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .RTS_SETUP_CYCLES     (RTS_C),
        .START_TIMEOUT_CYCLES (START_TO),
        .XFER_TIMEOUT_CYCLES  (XFER_TO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .tx_data_i     (tx_data),
        .tx_start_i    (tx_start),
        .ps2_clk_i     (ps2_clk_line),
        .ps2_data_i    (ps2_data_line),
        .ps2_clk_oe_o  (clk_oe),
        .ps2_data_oe_o (data_oe),
        .busy_o        (busy),
        .done_o        (done),
        .ack_err_o     (ack_err),
        .timeout_o     (timeout)
    );

    // Pulse monitor
    int   done_cnt    = 0;
    int   ack_err_cnt = 0;
    int   timeout_cnt = 0;
    logic done_ack_err = 1'b0;
    logic done_busy    = 1'b0;
    logic busy_after   = 1'b1;
    logic prev_done    = 1'b0;

    always @(negedge clk) begin
        if (prev_done) busy_after = busy;
        prev_done = done;
        if (done) begin
            done_cnt++;
            done_ack_err = ack_err;
            done_busy    = busy;
        end
        if (ack_err) ack_err_cnt++;
        if (timeout) timeout_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] expected_wire(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic measure_setup(output int inh, output int rts, output bit ok);
        inh = 0;
        rts = 0;
        while (clk_oe && !data_oe && inh < 1000) begin
            inh++;
            tick();
        end
        while (clk_oe && data_oe && rts < 1000) begin
            rts++;
            tick();
        end
        ok = (!clk_oe && data_oe);
    endtask

    task automatic dev_clock(input int nfalls, input logic ack, input bit spam,
                             output logic [10:0] samples, output int fall1_cyc);
        samples   = '0;
        fall1_cyc = 0;
        tick(10);
        samples[0] = ps2_data_line;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) begin
                dev_data = ack;
                tick(5);
            end
            dev_clk = 1'b0;
            if (i == 1) fall1_cyc = cyc;
            tick(HALF);
            if (i <= 10) samples[i] = ps2_data_line;
            dev_clk = 1'b1;
            tick(HALF);
            if (spam && i == 3) begin
                tx_data  = 8'h11;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
        end
        if (nfalls == 11) dev_data = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(3);
        checks++;
        if ({clk_oe, data_oe, busy, done, ack_err, timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {clk_oe, data_oe, busy, done, ack_err, timeout});
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if ({clk_oe, data_oe, busy, done, ack_err, timeout} !== 6'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected 000000",
                     {clk_oe, data_oe, busy, done, ack_err, timeout});
        end
    endtask

    task automatic test_send(input logic [7:0] d, input logic ack, input bit spam);
        int          d0, a0, t0, inh, rts, f1, guard;
        bit          ok;
        logic [10:0] samples;
        d0 = done_cnt;
        a0 = ack_err_cnt;
        t0 = timeout_cnt;
        start_tx(d);
        measure_setup(inh, rts, ok);
        checks++;
        if (inh != INH) begin
            failures++;
            $display("FAIL inhibit_len(%h): got %0d expected %0d", d, inh, INH);
        end
        checks++;
        if (rts != RTS_C) begin
            failures++;
            $display("FAIL rts_len(%h): got %0d expected %0d", d, rts, RTS_C);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_dev_lines(%h): got clk_oe=%b data_oe=%b expected 0/1", d, clk_oe, data_oe);
        end
        if (spam) begin
            tx_data  = 8'h11;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
        end
        dev_clock(11, ack, spam, samples, f1);
        checks++;
        if (samples !== expected_wire(d)) begin
            failures++;
            $display("FAIL wire_bits(%h): got %b expected %b", d, samples, expected_wire(d));
        end
        guard = 0;
        while (done_cnt == d0 && guard < 500) begin
            tick();
            guard++;
        end
        tick(3);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL done_pulses(%h): got %0d expected 1", d, done_cnt - d0);
        end
        checks++;
        if (done_ack_err !== ack) begin
            failures++;
            $display("FAIL ack_err_with_done(%h): got %b expected %b", d, done_ack_err, ack);
        end
        checks++;
        if (ack_err_cnt - a0 != int'(ack)) begin
            failures++;
            $display("FAIL ack_err_pulses(%h): got %0d expected %0d", d, ack_err_cnt - a0, ack);
        end
        checks++;
        if (done_busy !== 1'b1 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL busy_around_done(%h): got %b%b expected 10", d, done_busy, busy_after);
        end
        checks++;
        if (timeout_cnt != t0) begin
            failures++;
            $display("FAIL no_timeout(%h): got %0d expected 0", d, timeout_cnt - t0);
        end
        if (spam) begin
            tick(100);
            checks++;
            if (busy !== 1'b0 || done_cnt - d0 != 1) begin
                failures++;
                $display("FAIL busy_start_ignored: got busy=%b done=%0d expected busy=0 done=1",
                         busy, done_cnt - d0);
            end
        end
    endtask

    task automatic test_start_timeout();
        int d0, inh, rts, rel, guard;
        bit ok;
        d0 = done_cnt;
        start_tx(CMD_ENABLE);
        measure_setup(inh, rts, ok);
        rel   = cyc;
        guard = 0;
        while (!timeout && guard < 1000) begin
            tick();
            guard++;
        end
        checks++;
        if (cyc - rel != START_TO) begin
            failures++;
            $display("FAIL start_timeout_delay: got %0d expected %0d", cyc - rel, START_TO);
        end
        tick();
        checks++;
        if ({clk_oe, data_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL start_timeout_release: got %b expected 000", {clk_oe, data_oe, busy});
        end
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL start_timeout_no_done: got %0d expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_xfer_timeout();
        int          d0, inh, rts, f1, guard;
        bit          ok;
        logic [10:0] samples;
        d0 = done_cnt;
        start_tx(8'($urandom_range(0, 255)));
        measure_setup(inh, rts, ok);
        dev_clock(5, 1'b0, 1'b0, samples, f1);
        guard = 0;
        while (!timeout && guard < 3000) begin
            tick();
            guard++;
        end
        checks++;
        if (cyc != f1 + SYNC_LAT + XFER_TO) begin
            failures++;
            $display("FAIL xfer_timeout_delay: got %0d expected %0d", cyc - f1, SYNC_LAT + XFER_TO);
        end
        tick();
        checks++;
        if ({clk_oe, data_oe, busy} !== 3'b000 || done_cnt != d0) begin
            failures++;
            $display("FAIL xfer_timeout_release: got %b done=%0d expected 000 done=0",
                     {clk_oe, data_oe, busy}, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int          d0, t0, inh, rts, f1;
        bit          ok;
        logic [10:0] samples;
        logic [7:0]  d;
        d  = CMD_SET_RATE;
        d0 = done_cnt;
        t0 = timeout_cnt;
        start_tx(d);
        measure_setup(inh, rts, ok);
        dev_clock(4, 1'b0, 1'b0, samples, f1);
        checks++;
        if (data_oe !== ~d[3] || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_shift_lines: got data_oe=%b busy=%b expected %b 1", data_oe, busy, ~d[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({clk_oe, data_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_release: got %b expected 000", {clk_oe, data_oe, busy});
        end
        tick();
        rst = 1'b0;
        tick(5);
        checks++;
        if (done_cnt != d0 || timeout_cnt != t0) begin
            failures++;
            $display("FAIL reset_no_pulses: got done=%0d timeout=%0d expected 0 0",
                     done_cnt - d0, timeout_cnt - t0);
        end
        test_send(CMD_RESET, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_send(CMD_ENABLE, 1'b0, 1'b0);
        test_send(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            test_send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        test_start_timeout();
        test_xfer_timeout();
        test_reset_mid();
        test_send(CMD_SET_RATE, 1'b0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
